// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: 2-bit saturating counter table, optionally gshare-indexed,
// with self-sequenced table initialisation after reset and branch/mispredict statistics.
module branch_predictor_bht #(
    parameter int         LANES      = 2,
    parameter int         INDEX_BITS = 6,
    parameter int         GHR_BITS   = 0,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LANES-1:0]      pred_valid,
    input  logic [LANES*32-1:0]   pred_pc,
    output logic [LANES-1:0]      pred_taken,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    input  logic                  clear_stats,
    output logic                  ready,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic {INIT, RUN} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_BITS-1:0]  initPtr_q, initPtr_d;
    logic [31:0]            statBranches_q, statBranches_d;
    logic [31:0]            statMispredicts_q, statMispredicts_d;
    logic [1:0]             cntTable_q [DEPTH];

    logic [INDEX_BITS-1:0]  ghrIdx;
    logic [INDEX_BITS-1:0]  updIdx;
    logic [INDEX_BITS-1:0]  wrIdx;
    logic [1:0]             updCnt;
    logic [1:0]             updCntNext;
    logic [1:0]             wrData;
    logic                   wrEn;
    logic                   updAccept;
    logic                   unusedPcBits;

    assign ready        = (state_q == RUN);
    assign updAccept    = ready & upd_valid;
    assign updIdx       = upd_pc[INDEX_BITS-1:0] ^ ghrIdx;
    assign updCnt       = cntTable_q[updIdx];
    assign unusedPcBits = ^{pred_pc, upd_pc};

    // History only exists for gshare; bimodal builds fold the index term to zero.
    if (GHR_BITS > 0) begin : gGhr
        logic [GHR_BITS-1:0] ghr_q, ghr_d;

        always_comb begin
            ghr_d = ghr_q;
            if (updAccept) begin
                ghr_d = GHR_BITS'({ghr_q, upd_taken});
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ghr_q <= '0;
            end else begin
                ghr_q <= ghr_d;
            end
        end

        assign ghrIdx = INDEX_BITS'(ghr_q);
    end else begin : gNoGhr
        assign ghrIdx = '0;
    end

    always_comb begin
        state_d   = state_q;
        initPtr_d = initPtr_q;
        case (state_q)
            INIT: begin
                initPtr_d = initPtr_q + 1'b1;
                if (initPtr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // The init sweep owns the write port until RUN; resolved updates are dropped before that.
    always_comb begin
        updCntNext = updCnt;
        if (upd_taken) begin
            updCntNext = (updCnt == 2'b11) ? 2'b11 : updCnt + 2'd1;
        end else begin
            updCntNext = (updCnt == 2'b00) ? 2'b00 : updCnt - 2'd1;
        end

        wrEn   = 1'b0;
        wrIdx  = initPtr_q;
        wrData = CNT_INIT;
        if (state_q == INIT) begin
            wrEn = 1'b1;
        end else if (updAccept) begin
            wrEn   = 1'b1;
            wrIdx  = updIdx;
            wrData = updCntNext;
        end
    end

    always_comb begin
        statBranches_d    = statBranches_q;
        statMispredicts_d = statMispredicts_q;
        if (clear_stats) begin
            statBranches_d    = '0;
            statMispredicts_d = '0;
        end else if (updAccept) begin
            if (statBranches_q != '1) begin
                statBranches_d = statBranches_q + 32'd1;
            end
            if (upd_mispredict && (statMispredicts_q != '1)) begin
                statMispredicts_d = statMispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= INIT;
            initPtr_q         <= '0;
            statBranches_q    <= '0;
            statMispredicts_q <= '0;
        end else begin
            state_q           <= state_d;
            initPtr_q         <= initPtr_d;
            statBranches_q    <= statBranches_d;
            statMispredicts_q <= statMispredicts_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn) begin
            cntTable_q[wrIdx] <= wrData;
        end
    end

    // Lanes read the pre-update table, so a same-cycle update is never bypassed.
    for (genvar i = 0; i < LANES; i++) begin : gLane
        logic [INDEX_BITS-1:0] predIdx;
        assign predIdx       = pred_pc[32*i +: INDEX_BITS] ^ ghrIdx;
        assign pred_taken[i] = ready & pred_valid[i] & cntTable_q[predIdx][1];
    end

    assign stat_branches    = statBranches_q;
    assign stat_mispredicts = statMispredicts_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a bimodal instance and a 4-bit gshare instance
// driven with directed vectors; expectations are queued and drained by a negedge monitor.
module tb_branch_predictor_bht;

    typedef enum {K_PRED_B, K_READY_B, K_BR_B, K_MP_B, K_PRED_G, K_READY_G} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clock;
    logic        rstN;

    logic [1:0]  bPredValid, bPredTaken;
    logic [63:0] bPredPc;
    logic        bUpdValid, bUpdTaken, bUpdMisp, bClear, bReady;
    logic [31:0] bUpdPc, bStatBr, bStatMp;

    logic [1:0]  gPredValid, gPredTaken;
    logic [63:0] gPredPc;
    logic        gUpdValid, gUpdTaken, gReady;
    logic [31:0] gUpdPc, gStatBr, gStatMp;

    exp_t        scoreQ [$];
    exp_t        curExp;
    int          numCompared   = 0;
    int          numMismatched = 0;

    branch_predictor_bht #(.LANES(2), .INDEX_BITS(6), .GHR_BITS(0), .CNT_INIT(2'b01)) dutB (
        .clock(clock), .reset(rstN),
        .pred_valid(bPredValid), .pred_pc(bPredPc), .pred_taken(bPredTaken),
        .upd_valid(bUpdValid), .upd_pc(bUpdPc), .upd_taken(bUpdTaken),
        .upd_mispredict(bUpdMisp), .clear_stats(bClear), .ready(bReady),
        .stat_branches(bStatBr), .stat_mispredicts(bStatMp)
    );

    branch_predictor_bht #(.LANES(2), .INDEX_BITS(6), .GHR_BITS(4), .CNT_INIT(2'b01)) dutG (
        .clock(clock), .reset(rstN),
        .pred_valid(gPredValid), .pred_pc(gPredPc), .pred_taken(gPredTaken),
        .upd_valid(gUpdValid), .upd_pc(gUpdPc), .upd_taken(gUpdTaken),
        .upd_mispredict(1'b0), .clear_stats(1'b0), .ready(gReady),
        .stat_branches(gStatBr), .stat_mispredicts(gStatMp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic um, input logic clr);
        bPredValid = pv;
        bPredPc    = {pc1, pc0};
        bUpdValid  = uv;
        bUpdPc     = upc;
        bUpdTaken  = ut;
        bUpdMisp   = um;
        bClear     = clr;
    endtask

    task automatic applyGshare(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic uv, input logic [31:0] upc, input logic ut);
        gPredValid = pv;
        gPredPc    = {pc1, pc0};
        gUpdValid  = uv;
        gUpdPc     = upc;
        gUpdTaken  = ut;
    endtask

    task automatic expectOutput(input kind_e k, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = k;
        e.exp  = exp;
        e.name = name;
        scoreQ.push_back(e);
    endtask

    function automatic logic [31:0] sampleOutput(input kind_e k);
        case (k)
            K_PRED_B:  return {30'b0, bPredTaken};
            K_READY_B: return {31'b0, bReady};
            K_BR_B:    return bStatBr;
            K_MP_B:    return bStatMp;
            K_PRED_G:  return {30'b0, gPredTaken};
            K_READY_G: return {31'b0, gReady};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        act = sampleOutput(e.kind);
        numCompared++;
        if (act !== e.exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
        end
    endtask

    // Monitor drains every expectation queued since the previous falling edge.
    always @(negedge clock) begin
        while (scoreQ.size() > 0) begin
            curExp = scoreQ.pop_front();
            checkOutput(curExp);
        end
    end

    initial begin
        rstN = 1'b1;
        applyStimulus(2'b11, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyGshare(2'b11, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0);
        #1 rstN = 1'b0;

        repeat (2) begin
            tick();
            expectOutput(K_READY_B, 0, "rst_ready_b");
            expectOutput(K_PRED_B,  0, "rst_pred_b");
            expectOutput(K_BR_B,    0, "rst_stat_br");
            expectOutput(K_MP_B,    0, "rst_stat_mp");
            expectOutput(K_READY_G, 0, "rst_ready_g");
        end
        rstN = 1'b1;

        for (int k = 1; k <= 64; k++) begin
            tick();
            expectOutput(K_READY_B, (k >= 64) ? 32'd1 : 32'd0, "init_ready_b");
            expectOutput(K_READY_G, (k >= 64) ? 32'd1 : 32'd0, "init_ready_g");
            expectOutput(K_PRED_B,  0, "init_pred_b");
        end

        // Bimodal training on pc 5 and its alias pc 69.
        tick(); applyStimulus(2'b01, 32'd5, 32'd0,  1'b1, 32'd5,  1'b1, 1'b1, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "bimodal_same_cycle");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b11, "bimodal_taken");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "bimodal_not_taken");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b1, 32'd69, 1'b1, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "alias_floor");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b1, 32'd69, 1'b1, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "alias_weak");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b11, "alias_taken");

        // Saturation on pc 9: five taken, then walk back down.
        for (int i = 0; i < 5; i++) begin
            tick(); applyStimulus(2'b01, 32'd9, 32'd0, 1'b1, 32'd9, 1'b1, (i == 0), 1'b0);
            expectOutput(K_PRED_B, (i == 0) ? 32'd0 : 32'd1, "sat_rise");
        end
        tick(); applyStimulus(2'b01, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b01, "sat_at_3");
        tick(); applyStimulus(2'b01, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b01, "sat_one_nt");
        tick(); applyStimulus(2'b01, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "sat_two_nt");
        tick(); applyStimulus(2'b01, 32'd9, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "sat_three_nt");

        // Both lanes on the index being updated this very edge.
        tick(); applyStimulus(2'b11, 32'd3, 32'd3, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "no_bypass");
        tick(); applyStimulus(2'b11, 32'd3, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b11, "after_update");
        expectOutput(K_BR_B, 14, "stat_br_total");
        expectOutput(K_MP_B, 2,  "stat_mp_total");

        // Statistics clear, including clear winning over a same-cycle update.
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1);
        expectOutput(K_BR_B, 14, "pre_clear_br");
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 32'd20, 1'b1, 1'b1, 1'b0);
        expectOutput(K_BR_B, 0, "clear_br");
        expectOutput(K_MP_B, 0, "clear_mp");
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0);
        expectOutput(K_BR_B, 1, "count_br_1");
        expectOutput(K_MP_B, 1, "count_mp_1");
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 32'd20, 1'b0, 1'b0, 1'b1);
        expectOutput(K_BR_B, 2, "count_br_2");
        expectOutput(K_MP_B, 1, "count_mp_2");
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0);
        expectOutput(K_BR_B, 0, "clear_wins_br");
        expectOutput(K_MP_B, 0, "clear_wins_mp");
        tick(); applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0);
        expectOutput(K_BR_B, 1, "post_clear_br");

        // Gshare: T,T,N,T on pc 0 leaves ghr = 4'b1101.
        tick(); applyGshare(2'b01, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1);
        expectOutput(K_PRED_G, 2'b00, "gshare_first");
        tick(); applyGshare(2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1);
        tick(); applyGshare(2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
        tick(); applyGshare(2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1);
        tick(); applyGshare(2'b11, 32'd13, 32'd0, 1'b0, 32'd0, 1'b0);
        expectOutput(K_PRED_G, 2'b01, "gshare_13_vs_0");
        tick(); applyGshare(2'b11, 32'd14, 32'd11, 1'b0, 32'd0, 1'b0);
        expectOutput(K_PRED_G, 2'b10, "gshare_14_vs_11");

        // Reset mid-sweep must restart the full initialisation.
        tick(); applyStimulus(2'b11, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b0;
        expectOutput(K_READY_B, 0, "mid_rst_ready");
        expectOutput(K_PRED_B,  0, "mid_rst_pred");
        expectOutput(K_BR_B,    0, "mid_rst_br");
        tick(); rstN = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(); applyStimulus(2'b11, 32'd5, 32'd5, (k == 5), 32'd5, 1'b1, 1'b1, 1'b0);
            expectOutput(K_READY_B, 0, "partial_init_ready");
            expectOutput(K_BR_B,    0, "init_drop_br");
            expectOutput(K_MP_B,    0, "init_drop_mp");
        end
        rstN = 1'b0;
        expectOutput(K_READY_B, 0, "second_rst_ready");
        tick(); rstN = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick(); applyStimulus(2'b11, 32'd3, 32'd20, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            expectOutput(K_READY_B, (k >= 64) ? 32'd1 : 32'd0, "resweep_ready");
        end
        expectOutput(K_PRED_B, 2'b00, "reinit_counters");
        tick(); applyStimulus(2'b11, 32'd5, 32'd69, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        expectOutput(K_PRED_B, 2'b00, "reinit_alias");

        @(negedge clock);
        #1;
        if (scoreQ.size() != 0) begin
            numMismatched++;
            $display("[TB] FAIL queue_drain: %0d left, expected 0", scoreQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
